// File: rtl/nibble_serial_add_ctrl_pkg.sv
// Shared types and constants for the nibble-serial add/subtract sequencer.
// The FSM walks IDLE -> RUN (one nibble per cycle) -> DONE -> IDLE.
package nibble_serial_add_ctrl_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/nibble_serial_add_ctrl_if.sv
// Requester handshake plus the shared nibble-adder datapath connection.
// The master side is the requester together with the external adder cell.
interface nibble_serial_add_ctrl_if
    import nibble_serial_add_ctrl_pkg::*;
#(
    parameter int WORDS = 4
) ();

    logic                      start;
    logic                      sub;
    logic                      cin;
    logic [NIBBLE_W*WORDS-1:0] op_a;
    logic [NIBBLE_W*WORDS-1:0] op_b;
    logic                      busy;
    logic                      done;
    logic [NIBBLE_W*WORDS-1:0] result;
    logic                      cout;
    logic                      ovf;

    logic [NIBBLE_W-1:0]       add_a;
    logic [NIBBLE_W-1:0]       add_b;
    logic                      add_cin;
    logic [NIBBLE_W-1:0]       add_s;
    logic                      add_cout;

    modport master (
        output start, sub, cin, op_a, op_b, add_s, add_cout,
        input  busy, done, result, cout, ovf, add_a, add_b, add_cin
    );

    modport slave (
        input  start, sub, cin, op_a, op_b, add_s, add_cout,
        output busy, done, result, cout, ovf, add_a, add_b, add_cin
    );

endinterface

// File: rtl/nibble_serial_add_ctrl.sv
// Time-multiplexes one external 4-bit adder cell over WORDS cycles, LSB nibble
// first, to add or subtract two 4*WORDS-bit operands.
module nibble_serial_add_ctrl
    import nibble_serial_add_ctrl_pkg::*;
#(
    parameter int WORDS = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    nibble_serial_add_ctrl_if.slave bus
);

    localparam int W     = NIBBLE_W * WORDS;
    localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;

    state_t             state_q, state_d;
    logic [W-1:0]       a_q, b_q, result_q;
    logic               sub_q, carry_q, cout_q, ovf_q;
    logic [IDX_W-1:0]   idx_q;
    logic               last_nibble;
    logic               accept;
    logic [NIBBLE_W-1:0] a_nib, b_nib;

    assign last_nibble = (idx_q == IDX_W'(WORDS - 1));
    assign accept      = (state_q == IDLE) && bus.start;
    assign a_nib       = a_q[{idx_q, 2'b00} +: NIBBLE_W];
    assign b_nib       = b_q[{idx_q, 2'b00} +: NIBBLE_W];

    // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (bus.start) state_d = RUN;
            RUN:     if (last_nibble) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // The adder is only driven while a nibble is in flight; otherwise it sees zeros.
    always_comb begin
        bus.add_a   = '0;
        bus.add_b   = '0;
        bus.add_cin = 1'b0;
        if (state_q == RUN) begin
            bus.add_a   = a_nib;
            bus.add_b   = b_nib ^ {NIBBLE_W{sub_q}};
            bus.add_cin = carry_q;
        end
    end

    // NOTE: operand registers carry no reset; they are always reloaded at accept before being read.
    always_ff @(posedge clk) begin
        if (accept) begin
            a_q   <= bus.op_a;
            b_q   <= bus.op_b;
            sub_q <= bus.sub;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            result_q <= '0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
            idx_q    <= '0;
            carry_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                carry_q  <= bus.cin ^ bus.sub;
                idx_q    <= '0;
                result_q <= '0;
            end else if (state_q == RUN) begin
                result_q[{idx_q, 2'b00} +: NIBBLE_W] <= bus.add_s;
                carry_q <= bus.add_cout;
                idx_q   <= idx_q + 1'b1;
                if (last_nibble) begin
                    cout_q <= bus.add_cout;
                    ovf_q  <= (a_q[W-1] == (b_q[W-1] ^ sub_q)) &&
                              (bus.add_s[NIBBLE_W-1] != a_q[W-1]);
                end
            end
        end
    end

    assign bus.busy   = (state_q == RUN);
    assign bus.done   = (state_q == DONE);
    assign bus.result = result_q;
    assign bus.cout   = cout_q;
    assign bus.ovf    = ovf_q;

endmodule

// File: tb/tb_nibble_serial_add_ctrl.sv
// Directed bench for nibble_serial_add_ctrl with WORDS=4 and a behavioural
// 4-bit ripple-carry adder cell wired to the add_* ports.
module tb_nibble_serial_add_ctrl;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    nibble_serial_add_ctrl_if #(.WORDS(4)) bus ();

    nibble_serial_add_ctrl #(.WORDS(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // The shared adder cell: S = A + B + Cin over 4 bits, Cout from bit 4.
    assign {bus.add_cout, bus.add_s} = {1'b0, bus.add_a} + {1'b0, bus.add_b} + {4'b0, bus.add_cin};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Issue one request and wait (bounded) for done; returns at the negedge of the done cycle.
    task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic s, input logic c,
                          output int done_cyc, output int busy_cnt,
                          output logic [3:0] a0, output logic [3:0] b0, output logic c0);
        @(negedge clk);
        bus.op_a  = a;
        bus.op_b  = b;
        bus.sub   = s;
        bus.cin   = c;
        bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        done_cyc = -1;
        busy_cnt = 0;
        a0 = 'x; b0 = 'x; c0 = 'x;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (k == 1) begin
                a0 = bus.add_a;
                b0 = bus.add_b;
                c0 = bus.add_cin;
            end
            if (bus.busy) busy_cnt++;
            if (bus.done) begin
                done_cyc = k;
                break;
            end
        end
    endtask

    task automatic check_done_seen(input string name, input int done_cyc);
        checks++;
        if (done_cyc !== 5) begin
            errors++;
            $display("FAIL %s done_cycle got %0d expected 5", name, done_cyc);
        end
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        bus.start = 1'b0;
        bus.sub   = 1'b0;
        bus.cin   = 1'b0;
        bus.op_a  = '0;
        bus.op_b  = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({bus.busy, bus.done, bus.cout, bus.ovf} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_flags busy/done/cout/ovf got %b expected 0000",
                     {bus.busy, bus.done, bus.cout, bus.ovf});
        end
        checks++;
        if (bus.result !== 16'h0000) begin
            errors++;
            $display("FAIL reset_result got %h expected 0000", bus.result);
        end
        checks++;
        if ({bus.add_a, bus.add_b, bus.add_cin} !== 9'b0) begin
            errors++;
            $display("FAIL reset_adder_drive got %h expected 000", {bus.add_a, bus.add_b, bus.add_cin});
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_add();
        int dc, bc;
        logic [3:0] a0, b0;
        logic c0;
        run_op(16'h1234, 16'h4321, 1'b0, 1'b0, dc, bc, a0, b0, c0);
        check_done_seen("add_basic", dc);
        checks++;
        if ({bus.result, bus.cout, bus.ovf} !== {16'h5555, 2'b00}) begin
            errors++;
            $display("FAIL add_basic result/cout/ovf got %h/%b/%b expected 5555/0/0",
                     bus.result, bus.cout, bus.ovf);
        end
        checks++;
        if ({a0, b0, c0} !== {4'h4, 4'h1, 1'b0}) begin
            errors++;
            $display("FAIL add_first_nibble a/b/cin got %h/%h/%b expected 4/1/0", a0, b0, c0);
        end
        checks++;
        if (bc !== 4) begin
            errors++;
            $display("FAIL add_busy_cycles got %0d expected 4", bc);
        end
        @(negedge clk);
        checks++;
        if ({bus.done, bus.busy, bus.result} !== {2'b00, 16'h5555}) begin
            errors++;
            $display("FAIL add_after_done done/busy/result got %b/%b/%h expected 0/0/5555",
                     bus.done, bus.busy, bus.result);
        end

        run_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, dc, bc, a0, b0, c0);
        check_done_seen("add_ripple", dc);
        checks++;
        if ({bus.result, bus.cout, bus.ovf} !== {16'h0000, 2'b10}) begin
            errors++;
            $display("FAIL add_ripple result/cout/ovf got %h/%b/%b expected 0000/1/0",
                     bus.result, bus.cout, bus.ovf);
        end

        run_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, dc, bc, a0, b0, c0);
        checks++;
        if ({bus.result, bus.cout, bus.ovf} !== {16'h8000, 2'b01}) begin
            errors++;
            $display("FAIL add_ovf result/cout/ovf got %h/%b/%b expected 8000/0/1",
                     bus.result, bus.cout, bus.ovf);
        end
    endtask

    task automatic test_sub();
        int dc, bc;
        logic [3:0] a0, b0;
        logic c0;
        run_op(16'h0005, 16'h0007, 1'b1, 1'b0, dc, bc, a0, b0, c0);
        check_done_seen("sub_borrow", dc);
        checks++;
        if ({bus.result, bus.cout, bus.ovf} !== {16'hFFFE, 2'b00}) begin
            errors++;
            $display("FAIL sub_borrow result/cout/ovf got %h/%b/%b expected fffe/0/0",
                     bus.result, bus.cout, bus.ovf);
        end
        checks++;
        if ({a0, b0, c0} !== {4'h5, 4'h8, 1'b1}) begin
            errors++;
            $display("FAIL sub_first_nibble a/b/cin got %h/%h/%b expected 5/8/1", a0, b0, c0);
        end

        run_op(16'h0007, 16'h0005, 1'b1, 1'b0, dc, bc, a0, b0, c0);
        checks++;
        if ({bus.result, bus.cout, bus.ovf} !== {16'h0002, 2'b10}) begin
            errors++;
            $display("FAIL sub_pos result/cout/ovf got %h/%b/%b expected 0002/1/0",
                     bus.result, bus.cout, bus.ovf);
        end

        run_op(16'h8000, 16'h0001, 1'b1, 1'b0, dc, bc, a0, b0, c0);
        checks++;
        if ({bus.result, bus.cout, bus.ovf} !== {16'h7FFF, 2'b11}) begin
            errors++;
            $display("FAIL sub_ovf result/cout/ovf got %h/%b/%b expected 7fff/1/1",
                     bus.result, bus.cout, bus.ovf);
        end

        run_op(16'h0010, 16'h0003, 1'b1, 1'b1, dc, bc, a0, b0, c0);
        checks++;
        if ({bus.result, bus.cout, bus.ovf, c0} !== {16'h000C, 2'b10, 1'b0}) begin
            errors++;
            $display("FAIL sub_borrow_in result/cout/ovf/cin0 got %h/%b/%b/%b expected 000c/1/0/0",
                     bus.result, bus.cout, bus.ovf, c0);
        end
    endtask

    task automatic test_back_to_back();
        int busy_cnt, done_cnt;
        logic [15:0] res_at_done;
        @(negedge clk);
        bus.op_a  = 16'h1111;
        bus.op_b  = 16'h2222;
        bus.sub   = 1'b0;
        bus.cin   = 1'b1;
        bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        busy_cnt    = 0;
        done_cnt    = 0;
        res_at_done = 'x;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (bus.busy) busy_cnt++;
            if (bus.done) begin
                done_cnt++;
                res_at_done = bus.result;
            end
            if (k == 2) begin
                bus.op_a  = 16'h0F0F;
                bus.op_b  = 16'h0101;
                bus.sub   = 1'b1;
                bus.start = 1'b1;
            end else begin
                bus.start = 1'b0;
            end
        end
        checks++;
        if (res_at_done !== 16'h3334) begin
            errors++;
            $display("FAIL b2b_result got %h expected 3334", res_at_done);
        end
        checks++;
        if (done_cnt !== 1) begin
            errors++;
            $display("FAIL b2b_done_pulses got %0d expected 1", done_cnt);
        end
        checks++;
        if (busy_cnt !== 4) begin
            errors++;
            $display("FAIL b2b_busy_cycles got %0d expected 4", busy_cnt);
        end
    endtask

    task automatic test_mid_run_reset();
        int dc, bc;
        logic [3:0] a0, b0;
        logic c0;
        // Leave cout=1 and ovf=1 behind so the reset clearing them is observable.
        run_op(16'h8000, 16'h0001, 1'b1, 1'b0, dc, bc, a0, b0, c0);
        @(negedge clk);
        bus.op_a  = 16'h00FF;
        bus.op_b  = 16'h0001;
        bus.sub   = 1'b0;
        bus.cin   = 1'b0;
        bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if ({bus.busy, bus.done, bus.cout, bus.ovf, bus.result} !== {4'b0000, 16'h0000}) begin
            errors++;
            $display("FAIL midrun_reset busy/done/cout/ovf/result got %b%b%b%b/%h expected 0000/0000",
                     bus.busy, bus.done, bus.cout, bus.ovf, bus.result);
        end
        repeat (3) @(negedge clk);
        checks++;
        if ({bus.busy, bus.done} !== 2'b00) begin
            errors++;
            $display("FAIL midrun_stays_idle busy/done got %b%b expected 00", bus.busy, bus.done);
        end
        run_op(16'h00FF, 16'h0001, 1'b0, 1'b0, dc, bc, a0, b0, c0);
        check_done_seen("post_reset", dc);
        checks++;
        if ({bus.result, bus.cout, bus.ovf} !== {16'h0100, 2'b00}) begin
            errors++;
            $display("FAIL post_reset result/cout/ovf got %h/%b/%b expected 0100/0/0",
                     bus.result, bus.cout, bus.ovf);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_add();
        test_sub();
        test_back_to_back();
        test_mid_run_reset();
        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
